// File: rtl/y86_dmem_responder.sv
// Y86-64 data-memory responder: valid/ready request, fixed-latency 8-byte access, valid/ready response.
// Optional DMEM_STATS_EN adds completed read/write counters (rd_count_o, wr_count_o).
module y86_dmem_responder #(
    parameter int MEM_BYTES = 1024,
    parameter int LATENCY   = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [63:0] req_addr_i,
    input  logic [63:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [63:0] rsp_rdata_o,
    output logic        rsp_error_o
`ifdef DMEM_STATS_EN
    ,
    output logic [31:0] rd_count_o,
    output logic [31:0] wr_count_o
`endif
);

    localparam int AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD  = CW'(LATENCY - 1);
    localparam logic [64:0]   MEM_LIMIT = 65'(MEM_BYTES);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          we_q;
    logic [63:0]   addr_q;
    logic [63:0]   wdata_q;
    logic [63:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic          accept;
    logic          do_access;
    logic          range_err;
    logic [AW-1:0] base;
    logic [63:0]   rd_word;

    logic [7:0]    mem_q [MEM_BYTES];

    assign accept    = (state_q == IDLE) && req_valid_i;
    assign do_access = (state_q == BUSY) && (cnt_q == '0);
    // 65-bit compare so addresses near 2^64 cannot wrap into range
    assign range_err = ({1'b0, addr_q} + 65'd8) > MEM_LIMIT;
    assign base      = addr_q[AW-1:0];

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < 8; i++) begin
            rd_word[8*i +: 8] = mem_q[base + AW'(i)];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BUSY;
                    cnt_d   = CNT_LOAD;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    err_d   = range_err;
                    rdata_d = (range_err || we_q) ? '0 : rd_word;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                we_q    <= req_we_i;
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
            end
        end
    end

    // Storage is not reset; a reset before the access edge leaves it untouched
    always_ff @(posedge clk_i) begin
        if (do_access && we_q && !range_err) begin
            for (int i = 0; i < 8; i++) begin
                mem_q[base + AW'(i)] <= wdata_q[8*i +: 8];
            end
        end
    end

    assign req_ready_o = (state_q == IDLE);
    assign rsp_valid_o = (state_q == RESP);
    assign rsp_rdata_o = rdata_q;
    assign rsp_error_o = err_q;

`ifdef DMEM_STATS_EN
    logic [31:0] rd_cnt_q;
    logic [31:0] wr_cnt_q;
    logic        rsp_hs;

    assign rsp_hs = (state_q == RESP) && rsp_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else if (rsp_hs && !err_q) begin
            if (we_q) begin
                wr_cnt_q <= wr_cnt_q + 32'd1;
            end else begin
                rd_cnt_q <= rd_cnt_q + 32'd1;
            end
        end
    end

    assign rd_count_o = rd_cnt_q;
    assign wr_count_o = wr_cnt_q;
`endif

endmodule

// File: tb/tb_y86_dmem_responder.sv
// Bench for y86_dmem_responder: two instances (LATENCY 2 and 1) against a byte-array model.
// Counter checks are compiled in when DMEM_STATS_EN is defined.
module tb_y86_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        rv   [2];
    logic        rdy  [2];
    logic        rwe  [2];
    logic [63:0] radr [2];
    logic [63:0] rwd  [2];
    logic        rsv  [2];
    logic        rr   [2];
    logic [63:0] rrd  [2];
    logic        rer  [2];
`ifdef DMEM_STATS_EN
    logic [31:0] rdc  [2];
    logic [31:0] wrc  [2];
`endif

    int          checks = 0;
    int          errors = 0;
    int          lat    [2] = '{2, 1};
    int          msz    [2] = '{1024, 64};
    int          exp_rd [2] = '{0, 0};
    int          exp_wr [2] = '{0, 0};
    logic [7:0]  m      [2][1024];

    always #5 clk = ~clk;

    y86_dmem_responder #(.MEM_BYTES(1024), .LATENCY(2)) u0 (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (rv[0]),
        .req_ready_o (rdy[0]),
        .req_we_i    (rwe[0]),
        .req_addr_i  (radr[0]),
        .req_wdata_i (rwd[0]),
        .rsp_valid_o (rsv[0]),
        .rsp_ready_i (rr[0]),
        .rsp_rdata_o (rrd[0]),
        .rsp_error_o (rer[0])
`ifdef DMEM_STATS_EN
        ,
        .rd_count_o  (rdc[0]),
        .wr_count_o  (wrc[0])
`endif
    );

    y86_dmem_responder #(.MEM_BYTES(64), .LATENCY(1)) u1 (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (rv[1]),
        .req_ready_o (rdy[1]),
        .req_we_i    (rwe[1]),
        .req_addr_i  (radr[1]),
        .req_wdata_i (rwd[1]),
        .rsp_valid_o (rsv[1]),
        .rsp_ready_i (rr[1]),
        .rsp_rdata_o (rrd[1]),
        .rsp_error_o (rer[1])
`ifdef DMEM_STATS_EN
        ,
        .rd_count_o  (rdc[1]),
        .wr_count_o  (wrc[1])
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_stats(input int d);
`ifdef DMEM_STATS_EN
        chk("rd_count", 64'(rdc[d]), 64'(exp_rd[d]));
        chk("wr_count", 64'(wrc[d]), 64'(exp_wr[d]));
`endif
    endtask

    // One full transaction; called at posedge+1 with the device idle
    task automatic xact(input int d, input logic we, input logic [63:0] a,
                        input logic [63:0] wd, input int stall);
        bit          e;
        logic [63:0] exp_v;
        logic [63:0] hold_d;
        logic        hold_e;
        bit          stable;
        int          n;
        e     = ({1'b0, a} + 65'd8) > 65'(msz[d]);
        exp_v = '0;
        if (!e && !we) begin
            for (int i = 0; i < 8; i++) exp_v[8*i +: 8] = m[d][int'(a) + i];
        end
        chk("req_ready_idle", 64'(rdy[d]), 64'd1);
        rwe[d]  = we;
        radr[d] = a;
        rwd[d]  = wd;
        rv[d]   = 1'b1;
        rr[d]   = 1'b0;
        @(posedge clk); #1;
        chk("req_ready_busy", 64'(rdy[d]), 64'd0);
        n = 0;
        while (!rsv[d] && n < 16) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", 64'(n), 64'(lat[d]));
        chk("rsp_error", 64'(rer[d]), 64'(e));
        chk("rsp_rdata", rrd[d], exp_v);
        hold_d = rrd[d];
        hold_e = rer[d];
        stable = 1'b1;
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            if (rsv[d] !== 1'b1 || rrd[d] !== hold_d || rer[d] !== hold_e || rdy[d] !== 1'b0)
                stable = 1'b0;
        end
        if (stall > 0) chk("stall_stable", 64'(stable), 64'd1);
        rr[d] = 1'b1;
        @(posedge clk); #1;
        rr[d] = 1'b0;
        rv[d] = 1'b0;
        chk("rsp_valid_after_hs", 64'(rsv[d]), 64'd0);
        chk("req_ready_after_hs", 64'(rdy[d]), 64'd1);
        if (!e) begin
            if (we) begin
                for (int i = 0; i < 8; i++) m[d][int'(a) + i] = wd[8*i +: 8];
                exp_wr[d]++;
            end else begin
                exp_rd[d]++;
            end
        end
    endtask

    initial begin
        logic [63:0] a;
        int          r;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 1024; i++) m[d][i] = 8'h00;
            rv[d] = 0; rwe[d] = 0; radr[d] = 0; rwd[d] = 0; rr[d] = 0;
        end
        rst = 1'b1;
        #3;
        chk("reset_rsp_valid", 64'(rsv[0]), 64'd0);
        chk("reset_req_ready", 64'(rdy[0]), 64'd1);
        chk("reset_rdata", rrd[0], 64'd0);
        chk("reset_error", 64'(rer[0]), 64'd0);
        chk_stats(0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int w = 0; w < 128; w++) xact(0, 1'b1, 64'(w * 8), 64'd0, 0);
        for (int w = 0; w < 8; w++) xact(1, 1'b1, 64'(w * 8), 64'd0, 0);

        xact(0, 1'b1, 64'h10, 64'h1122_3344_5566_7788, 0);
        xact(0, 1'b0, 64'h10, 64'd0, 0);
        xact(0, 1'b0, 64'h13, 64'd0, 5);
        xact(0, 1'b0, 64'd1016, 64'd0, 0);
        xact(0, 1'b0, 64'd1017, 64'd0, 0);
        xact(0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 2);
        xact(0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 0);
        xact(0, 1'b1, 64'd1017, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        xact(0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        xact(0, 1'b0, 64'd1016, 64'd0, 0);

        xact(1, 1'b1, 64'd8, 64'hA5A5_0102_0304_5A5A, 1);
        xact(1, 1'b0, 64'd8, 64'd0, 0);
        xact(1, 1'b0, 64'd11, 64'd0, 3);
        xact(1, 1'b0, 64'd57, 64'd0, 0);
        xact(1, 1'b0, 64'd56, 64'd0, 0);

        chk_stats(0);
        chk_stats(1);

        // Reset while a write is in flight: it must never reach storage
        chk("req_ready_pre_rst", 64'(rdy[0]), 64'd1);
        rwe[0]  = 1'b1;
        radr[0] = 64'h40;
        rwd[0]  = 64'hDEAD_BEEF_CAFE_F00D;
        rv[0]   = 1'b1;
        @(posedge clk); #1;
        chk("busy_before_rst", 64'(rdy[0]), 64'd0);
        rst = 1'b1;
        #1;
        chk("rst_mid_rsp_valid", 64'(rsv[0]), 64'd0);
        chk("rst_mid_req_ready", 64'(rdy[0]), 64'd1);
        chk("rst_mid_rdata", rrd[0], 64'd0);
        chk("rst_mid_error", 64'(rer[0]), 64'd0);
        rv[0] = 1'b0;
        exp_rd = '{0, 0};
        exp_wr = '{0, 0};
        chk_stats(0);
        @(posedge clk); #1;
        rst = 1'b0;
        xact(0, 1'b0, 64'h40, 64'd0, 0);
        xact(0, 1'b0, 64'h10, 64'd0, 0);
        xact(0, 1'b0, 64'h3, 64'd0, 0);
        xact(0, 1'b1, 64'h80, 64'h0102_0304_0506_0708, 0);
        xact(0, 1'b1, 64'h81, 64'h1111_2222_3333_4444, 1);
        xact(0, 1'b0, 64'd1020, 64'd0, 0);
`ifdef DMEM_STATS_EN
        chk("rd_count_3", 64'(rdc[0]), 64'd3);
        chk("wr_count_2", 64'(wrc[0]), 64'd2);
`endif

        for (int k = 0; k < 200; k++) begin
            r = $urandom_range(0, 9);
            if (r == 0) a = {$urandom, $urandom};
            else if (r == 1) a = 64'($urandom_range(1017, 1030));
            else a = 64'($urandom_range(0, 1016));
            xact(0, 1'($urandom_range(0, 1)), a, {$urandom, $urandom},
                 $urandom_range(0, 3));
        end

        chk_stats(0);
        chk_stats(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
